// File: rtl/mem_io_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_bridge_pkg
//  Description : Shared address map, decode helper and read-source encoding
//                for the cpu memory bus bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_io_bridge_pkg;

    localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
    localparam logic [17:0] IO_CTRL_ADDR = 18'h30004;
    localparam logic [1:0]  IO_WINDOW    = 2'b11;

    typedef enum logic {
        RD_RAM = 1'b0,
        RD_IO  = 1'b1
    } rd_src_e;

    function automatic logic is_io_addr(input logic [17:0] addr);
        return addr[17:16] == IO_WINDOW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_bridge_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Power-of-two depth FIFO with registered occupancy; a push to
//                a full FIFO is accepted when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full       = (r_count == CW'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign w_pop_ok     = i_pop & ~o_empty;
    assign w_push_ok    = i_push & (~o_full | w_pop_ok);
    assign o_count_next = r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    assign o_rdata      = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= o_count_next;
        end
    end

    // Storage carries no reset; only pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_bridge
//  Description : Decodes cpu byte-bus accesses to block RAM or the I/O window
//                and owns the UART TX FIFO, RX pop, cycle counter and stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int TX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2,
    parameter int RAM_AW      = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [31:0]       cpu_a,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_din,
    output logic              io_buffer_full,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    output logic              program_end,
    output logic              tx_overflow
);
    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] c_full_thresh = CW'(TX_DEPTH - FULL_MARGIN);

    logic [17:0]   w_addr;
    logic          w_is_io;
    logic          w_io_rd;
    logic          w_io_wr;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_count_next;
    logic [7:0]    w_io_rdata;
    logic          w_snap_load;
    logic          w_unused;

    logic [31:0]   r_counter;
    logic [31:8]   r_snap;
    logic [7:0]    r_io_rdata;
    rd_src_e       r_rd_src;
    logic          r_rd_valid;
    logic          r_io_full;
    logic          r_tx_ovf;
    logic          r_stop_req;
    logic          r_prog_end;

    assign w_addr    = cpu_a[17:0];
    assign w_is_io   = is_io_addr(w_addr);
    assign w_io_rd   = rdy_in & ~cpu_wr & w_is_io;
    assign w_io_wr   = rdy_in &  cpu_wr & w_is_io;
    assign w_unused  = ^cpu_a[31:18];

    assign ram_a     = cpu_a[RAM_AW-1:0];
    assign ram_we    = rdy_in & cpu_wr & ~w_is_io;
    assign ram_wdata = cpu_dout;

    assign rx_pop    = w_io_rd & (w_addr == IO_DATA_ADDR) & rx_valid;
    assign w_tx_push = w_io_wr & (w_addr == IO_DATA_ADDR) & (cpu_dout != 8'h00);
    assign w_tx_pop  = tx_ready & ~w_fifo_empty;
    assign tx_valid  = ~w_fifo_empty;

    byte_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .i_clk        (clk_in),
        .i_rst_n      (rst_in),
        .i_push       (w_tx_push),
        .i_wdata      (cpu_dout),
        .i_pop        (w_tx_pop),
        .o_rdata      (tx_data),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_count_next (w_count_next)
    );

    // Bytes 1..3 come from the snapshot so a multi-byte counter read is coherent.
    always_comb begin
        w_io_rdata  = 8'h00;
        w_snap_load = 1'b0;
        case (w_addr)
            IO_DATA_ADDR:         w_io_rdata = rx_valid ? rx_data : 8'h00;
            IO_CTRL_ADDR: begin
                w_io_rdata  = r_counter[7:0];
                w_snap_load = 1'b1;
            end
            IO_CTRL_ADDR + 18'd1: w_io_rdata = r_snap[15:8];
            IO_CTRL_ADDR + 18'd2: w_io_rdata = r_snap[23:16];
            IO_CTRL_ADDR + 18'd3: w_io_rdata = r_snap[31:24];
            default:              w_io_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_counter <= 32'd0;
        else         r_counter <= r_counter + 32'd1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_snap     <= '0;
            r_io_rdata <= 8'h00;
            r_rd_src   <= RD_RAM;
            r_rd_valid <= 1'b0;
            r_io_full  <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_stop_req <= 1'b0;
            r_prog_end <= 1'b0;
        end else begin
            r_io_full <= (w_count_next >= c_full_thresh);
            if (w_tx_push && w_fifo_full && !w_tx_pop) r_tx_ovf <= 1'b1;
            if (w_io_wr && (w_addr == IO_CTRL_ADDR))   r_stop_req <= 1'b1;
            // A push in the same cycle would refill the FIFO, so it blocks the end flag.
            if (r_stop_req && w_fifo_empty && !w_tx_push) r_prog_end <= 1'b1;
            if (rdy_in) begin
                r_rd_valid <= 1'b1;
                r_rd_src   <= w_is_io ? RD_IO : RD_RAM;
                if (w_io_rd) begin
                    r_io_rdata <= w_io_rdata;
                    if (w_snap_load) r_snap <= r_counter[31:8];
                end
            end
        end
    end

    // Until the first access after reset there is no read data to return.
    assign cpu_din        = !r_rd_valid        ? 8'h00 :
                            (r_rd_src == RD_RAM) ? ram_rdata : r_io_rdata;
    assign io_buffer_full = r_io_full;
    assign tx_overflow    = r_tx_ovf;
    assign program_end    = r_prog_end;

endmodule
`default_nettype wire

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the cpu core's byte-wide memory bus (mem_a/mem_dout/mem_wr/mem_din/io_buffer_full).
- Decodes each access to block RAM or the memory-mapped I/O window (a[17:16]==2'b11) and returns read data one cycle later.
- Owns the UART TX byte FIFO, the RX pop strobe, the free-running cycle counter behind 0x30004 and the program-end flag.

Parameters:
TX_DEPTH, 16, TX FIFO entries (power of two, >=4)
FULL_MARGIN, 2, io_buffer_full asserts when occupancy >= TX_DEPTH-FULL_MARGIN (covers writes already in flight)
RAM_AW, 17, RAM byte-address width

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global ready; low freezes all state except cycle counter
cpu_a  in  32  cpu address (only [17:0] decoded)
cpu_dout  in  8  cpu write data
cpu_wr  in  1  1=write, 0=read (every non-reset cycle with rdy_in is an access)
cpu_din  out  8  read data to cpu, valid the cycle after the read
io_buffer_full  out  1  TX FIFO near-full back-pressure to cpu
ram_a  out  RAM_AW  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data (synchronous, 1-cycle latency)
tx_data  out  8  UART TX byte
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  UART accepts tx_data when tx_valid&tx_ready
rx_data  in  8  UART RX byte
rx_valid  in  1  RX byte available
rx_pop  out  1  one-cycle strobe consuming rx_data
program_end  out  1  sticky: stop requested and TX FIFO drained
tx_overflow  out  1  sticky: byte written while FIFO completely full

Behaviour:
- Reset (rst_in=0, async): FIFO empty, counter=0, cpu_din=0, io_buffer_full=0, ram_we=0, tx_valid=0, rx_pop=0, program_end=0, tx_overflow=0, rd_src=RAM.
- Decode: is_io = cpu_a[17:16]==2'b11; RAM path ram_a=cpu_a[RAM_AW-1:0], ram_we=cpu_wr&~is_io&rdy_in, ram_wdata=cpu_dout (combinational).
- Read latency: registered rd_src (RAM/IO) and io_rdata captured on the access cycle; next cycle cpu_din = rd_src==RAM ? ram_rdata : io_rdata. With rdy_in low, rd_src/io_rdata hold.
- IO read 0x30000: if rx_valid, io_rdata<=rx_data and rx_pop=1 that cycle; else io_rdata<=0x00, no pop.
- IO read 0x30004: snapshot<=counter, io_rdata<=counter[7:0]. Reads of 0x30005/6/7 return snapshot bytes 1/2/3 (coherent multi-byte read). Other IO addresses read 0x00.
- Cycle counter: 32-bit, +1 every clk_in after reset (independent of rdy_in), wraps at 2^32.
- IO write 0x30000: byte 0x00 ignored; else pushed to TX FIFO. If FIFO full (occupancy==TX_DEPTH) byte dropped, tx_overflow<=1.
- IO write 0x30004: stop_req<=1 (sticky). program_end<=1 first cycle stop_req=1 and FIFO empty and no push pending.
- TX drain: pop on tx_valid&tx_ready regardless of rdy_in. Simultaneous push and pop: occupancy unchanged, both take effect; push to a full FIFO with same-cycle pop is accepted.
- io_buffer_full: registered, = (occupancy_next >= TX_DEPTH-FULL_MARGIN).
- Writes to other IO addresses ignored. RAM and IO never both enabled in one cycle.

Decomposition:
- Shared package: IO_DATA_ADDR=18'h30000, IO_CTRL_ADDR=18'h30004, IO window decode constant, rd_src enum {RD_RAM, RD_IO}.
- One sub-module: byte_fifo (parameterised depth, push/pop/count, full/empty), instantiated for TX.

Test Plan:
- Write 0x41 to 0x00010, read 0x00010 -> ram_we pulse with ram_a=0x10; next cycle cpu_din=0x41.
- tx_ready=0, write 0x41..0x4E (14 bytes) to 0x30000 -> io_buffer_full=1 after 14th; 0x00 write leaves count unchanged; 17th byte with FIFO at 16 -> tx_overflow=1.
- rx_valid=1, rx_data=0x5A, read 0x30000 -> rx_pop one cycle, next cycle cpu_din=0x5A; rx_valid=0 read -> cpu_din=0x00, no pop.
- Counter=0x12345678 at read of 0x30004, then 0x30005/6/7 -> cpu_din 0x78,0x56,0x34,0x12 despite counter advancing.
- 3 bytes queued, tx_ready=0, write 0x30004 -> program_end stays 0; tx_ready=1 -> program_end=1 the cycle after FIFO empties.
- rst_in low mid-drain with FIFO at 5 -> tx_valid=0, counter=0, program_end=0 immediately (async).
